// File: rtl/instr_seq_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state encoding,
// state width and default performance-counter width.
package instr_seq_pkg;

   localparam int unsigned STATE_W       = 3;
   localparam int unsigned CNT_W_DEFAULT = 32;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 3'd0,
      S_FETCH    = 3'd1,
      S_DECODE   = 3'd2,
      S_INDIRECT = 3'd3,
      S_EXECUTE  = 3'd4,
      S_HALTED   = 3'd5
   } state_e;

endpackage

// File: rtl/instr_seq_perf_cnt.sv
// Busy-cycle and retired-instruction counters for the instruction sequencer.
// Only instantiated when INSTR_SEQ_PERF_CNT_EN is defined.
module instr_seq_perf_cnt
   import instr_seq_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             busy_i,
   input  logic             retire_i,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] retired_cnt_o
);

   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   // Both counters wrap naturally modulo 2^CNT_W.
   always_comb begin
      cycle_d   = cycle_q;
      retired_d = retired_q;
      if (busy_i)   cycle_d   = cycle_q + CNT_W'(1);
      if (retire_i) retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         retired_q <= retired_d;
      end
   end

   assign cycle_cnt_o   = cycle_q;
   assign retired_cnt_o = retired_q;

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/INDIRECT/EXECUTE FSM with
// Mealy single-cycle strobes paced by mem_ready. Counters under INSTR_SEQ_PERF_CNT_EN.
module instr_sequencer
   import instr_seq_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               mem_ready,
   input  logic               addr_mode,
   input  logic               store,
   input  logic               halt_op,
   output logic               mem_req,
   output logic               ir_load,
   output logic               pc_en,
   output logic               acc_load_en,
   output logic               mem_we,
   output logic               busy,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   retired_cnt
);

   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and strobes; strobes only fire on the mem_ready completion cycle.
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      ir_load     = 1'b0;
      pc_en       = 1'b0;
      acc_load_en = 1'b0;
      mem_we      = 1'b0;
      busy        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            busy = 1'b1;
            if (halt_op)        state_d = S_HALTED;
            else if (addr_mode) state_d = S_INDIRECT;
            else                state_d = S_EXECUTE;
         end
         S_INDIRECT: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ready) begin
               pc_en       = 1'b1;
               mem_we      = store;
               acc_load_en = ~store;
               state_d     = run ? S_FETCH : S_IDLE;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // A reset cycle must never commit a partial instruction.
      if (reset) begin
         mem_req     = 1'b0;
         ir_load     = 1'b0;
         pc_en       = 1'b0;
         acc_load_en = 1'b0;
         mem_we      = 1'b0;
      end
   end

   assign state = state_q;

`ifdef INSTR_SEQ_PERF_CNT_EN
   instr_seq_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk           (clk),
      .reset         (reset),
      .busy_i        (busy),
      .retire_i      (pc_en),
      .cycle_cnt_o   (cycle_cnt),
      .retired_cnt_o (retired_cnt)
   );
`else
   assign cycle_cnt   = '0;
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// instruction streams checked against a per-instruction cycle-trace model.
module tb_instr_sequencer;

`ifdef INSTR_SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, run, mem_ready, addr_mode, store, halt_op;
   logic        mem_req, ir_load, pc_en, acc_load_en, mem_we, busy;
   logic [2:0]  state;
   logic [31:0] cycle_cnt, retired_cnt;

   int n_pass  = 0;
   int n_total = 0;

   // {state[8:6], busy[5], mem_req[4], ir_load[3], pc_en[2], acc_load_en[1], mem_we[0]}
   typedef struct packed {
      logic       r;
      logic       rd;
      logic       am;
      logic       st;
      logic [8:0] e;
   } rec_t;

   instr_sequencer #(.CNT_W(32)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .mem_ready   (mem_ready),
      .addr_mode   (addr_mode),
      .store       (store),
      .halt_op     (halt_op),
      .mem_req     (mem_req),
      .ir_load     (ir_load),
      .pc_en       (pc_en),
      .acc_load_en (acc_load_en),
      .mem_we      (mem_we),
      .busy        (busy),
      .state       (state),
      .cycle_cnt   (cycle_cnt),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] obs();
      return {state, busy, mem_req, ir_load, pc_en, acc_load_en, mem_we};
   endfunction

   function automatic logic [8:0] ex(input logic [2:0] s, input logic b, input logic rq,
                                     input logic il, input logic pc, input logic ac,
                                     input logic we);
      return {s, b, rq, il, pc, ac, we};
   endfunction

   // One clock cycle: drive inputs just after the edge, return at the sampling point.
   task automatic cyc(input logic rs, input logic r, input logic rd, input logic am,
                      input logic st, input logic ho);
      @(posedge clk);
      #1;
      reset = rs; run = r; mem_ready = rd; addr_mode = am; store = st; halt_op = ho;
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      n_total++;
      if ({mem_req, ir_load, pc_en, acc_load_en, mem_we} !== 5'b0)
         $display("FAIL reset_strobes: got %b want 00000",
                  {mem_req, ir_load, pc_en, acc_load_en, mem_we});
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 0))
         $display("FAIL reset_idle: got %b want %b", obs(), ex(0, 0, 0, 0, 0, 0, 0));
      else n_pass++;
      n_total++;
      if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0)
         $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, retired_cnt);
      else n_pass++;
   endtask

   task automatic test_direct();
      logic [8:0] e [5];
      logic       rn [5];
      e[0] = ex(0, 0, 0, 0, 0, 0, 0); rn[0] = 1'b1;
      e[1] = ex(1, 1, 1, 1, 0, 0, 0); rn[1] = 1'b1;
      e[2] = ex(2, 1, 0, 0, 0, 0, 0); rn[2] = 1'b1;
      e[3] = ex(4, 1, 1, 0, 1, 1, 0); rn[3] = 1'b0;
      e[4] = ex(0, 0, 0, 0, 0, 0, 0); rn[4] = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, rn[i], 1'b1, 1'b0, 1'b0, 1'b0);
         n_total++;
         if (obs() !== e[i])
            $display("FAIL direct_c%0d: got %b want %b", i, obs(), e[i]);
         else n_pass++;
      end
      n_total++;
      if (cycle_cnt !== (PERF ? 32'd3 : 32'd0) || retired_cnt !== (PERF ? 32'd1 : 32'd0))
         $display("FAIL direct_cnt: got %0d/%0d want %0d/%0d", cycle_cnt, retired_cnt,
                  PERF ? 3 : 0, PERF ? 1 : 0);
      else n_pass++;
   endtask

   task automatic test_indirect_store();
      logic [8:0] e [6];
      logic       rn [6];
      e[0] = ex(0, 0, 0, 0, 0, 0, 0); rn[0] = 1'b1;
      e[1] = ex(1, 1, 1, 1, 0, 0, 0); rn[1] = 1'b1;
      e[2] = ex(2, 1, 0, 0, 0, 0, 0); rn[2] = 1'b1;
      e[3] = ex(3, 1, 1, 0, 0, 0, 0); rn[3] = 1'b1;
      e[4] = ex(4, 1, 1, 0, 1, 0, 1); rn[4] = 1'b0;
      e[5] = ex(0, 0, 0, 0, 0, 0, 0); rn[5] = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, rn[i], 1'b1, 1'b1, 1'b1, 1'b0);
         n_total++;
         if (obs() !== e[i])
            $display("FAIL indirect_store_c%0d: got %b want %b", i, obs(), e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_fetch_wait();
      int n_busy = 0, n_fetch = 0, n_irl = 0, irl_at = -1;
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, k < 3, k >= 2, 1'b0, 1'b0, 1'b0);
         if (state == 3'd0) break;
         if (busy) n_busy++;
         if (state == 3'd1) n_fetch++;
         if (ir_load) begin n_irl++; irl_at = k; end
      end
      n_total++;
      if (n_busy !== 5) $display("FAIL fetch_wait_len: got %0d want 5", n_busy);
      else n_pass++;
      n_total++;
      if (n_fetch !== 3) $display("FAIL fetch_wait_fetch: got %0d want 3", n_fetch);
      else n_pass++;
      n_total++;
      if (n_irl !== 1 || irl_at !== 2)
         $display("FAIL fetch_wait_irl: got %0d@%0d want 1@2", n_irl, irl_at);
      else n_pass++;
   endtask

   task automatic test_halt();
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      n_total++;
      if (obs() !== ex(2, 1, 0, 0, 0, 0, 0))
         $display("FAIL halt_decode: got %b want %b", obs(), ex(2, 1, 0, 0, 0, 0, 0));
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, i[0], 1'b1, 1'b0, 1'b0, 1'b1);
         n_total++;
         if (obs() !== ex(5, 0, 0, 0, 0, 0, 0))
            $display("FAIL halt_hold_c%0d: got %b want %b", i, obs(), ex(5, 0, 0, 0, 0, 0, 0));
         else n_pass++;
      end
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 0))
         $display("FAIL halt_reset: got %b want %b", obs(), ex(0, 0, 0, 0, 0, 0, 0));
      else n_pass++;
   endtask

   task automatic test_run_drop();
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(2, 1, 0, 0, 0, 0, 0))
         $display("FAIL run_drop_decode: got %b want %b", obs(), ex(2, 1, 0, 0, 0, 0, 0));
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(4, 1, 1, 0, 1, 1, 0))
         $display("FAIL run_drop_exec: got %b want %b", obs(), ex(4, 1, 1, 0, 1, 1, 0));
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         n_total++;
         if (obs() !== ex(0, 0, 0, 0, 0, 0, 0))
            $display("FAIL run_drop_idle_c%0d: got %b want %b", i, obs(), ex(0, 0, 0, 0, 0, 0, 0));
         else n_pass++;
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(1, 1, 1, 0, 0, 0, 0))
         $display("FAIL run_drop_restart: got %b want %b", obs(), ex(1, 1, 1, 0, 0, 0, 0));
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (state !== 3'd4 || {mem_req, ir_load, pc_en, acc_load_en, mem_we} !== 5'b0)
         $display("FAIL reset_mid_exec: got state %0d strobes %b want 4 00000", state,
                  {mem_req, ir_load, pc_en, acc_load_en, mem_we});
      else n_pass++;
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (obs() !== ex(0, 0, 0, 0, 0, 0, 0) || cycle_cnt !== 32'd0 || retired_cnt !== 32'd0)
         $display("FAIL reset_mid_after: got %b %0d/%0d want %b 0/0", obs(), cycle_cnt,
                  retired_cnt, ex(0, 0, 0, 0, 0, 0, 0));
      else n_pass++;
   endtask

   // Random instructions expanded into an expected per-cycle trace, phase by phase.
   task automatic test_random();
      rec_t        q[$];
      logic        am, st, ra;
      int unsigned w, ec, er;
      do_reset();
      q.push_back({1'b1, 1'($urandom), 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0)});
      for (int n = 0; n < 30; n++) begin
         am = 1'($urandom);
         st = 1'($urandom);
         ra = ($urandom % 4) != 0;
         w  = $urandom % 3;
         repeat (w) q.push_back({1'($urandom), 1'b0, am, st, ex(1, 1, 1, 0, 0, 0, 0)});
         q.push_back({1'($urandom), 1'b1, am, st, ex(1, 1, 1, 1, 0, 0, 0)});
         q.push_back({1'($urandom), 1'($urandom), am, st, ex(2, 1, 0, 0, 0, 0, 0)});
         if (am) begin
            w = $urandom % 3;
            repeat (w) q.push_back({1'($urandom), 1'b0, am, st, ex(3, 1, 1, 0, 0, 0, 0)});
            q.push_back({1'($urandom), 1'b1, am, st, ex(3, 1, 1, 0, 0, 0, 0)});
         end
         w = $urandom % 3;
         repeat (w) q.push_back({1'($urandom), 1'b0, am, st, ex(4, 1, 1, 0, 0, 0, 0)});
         q.push_back({ra, 1'b1, am, st, ex(4, 1, 1, 0, 1, ~st, st)});
         if (!ra) q.push_back({1'b1, 1'($urandom), am, st, ex(0, 0, 0, 0, 0, 0, 0)});
      end
      ec = 0;
      er = 0;
      foreach (q[i]) begin
         cyc(1'b0, q[i].r, q[i].rd, q[i].am, q[i].st, 1'b0);
         n_total++;
         if (obs() !== q[i].e)
            $display("FAIL random_c%0d: got %b want %b", i, obs(), q[i].e);
         else n_pass++;
         n_total++;
         if (cycle_cnt !== (PERF ? 32'(ec) : 32'd0) || retired_cnt !== (PERF ? 32'(er) : 32'd0))
            $display("FAIL random_cnt_c%0d: got %0d/%0d want %0d/%0d", i, cycle_cnt,
                     retired_cnt, PERF ? ec : 0, PERF ? er : 0);
         else n_pass++;
         ec += 32'(q[i].e[5]);
         er += 32'(q[i].e[2]);
      end
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; mem_ready = 1'b0;
      addr_mode = 1'b0; store = 1'b0; halt_op = 1'b0;
      test_reset();
      test_direct();
      test_indirect_store();
      test_fetch_wait();
      test_halt();
      test_run_drop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
      $fatal(1);
   end

endmodule
